// File: rtl/instr_queue.sv
// instr_queue: decoded-instruction FIFO between decode and dual issue.
// Accepts 0-2 and retires 0-2 entries per cycle; head pair always visible.
package instr_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  fu;
  } decode_t;
endpackage

module instr_queue
  import instr_queue_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  decode_t [1:0] in_instr,
  input  logic    [1:0] in_cnt,
  output logic          queue_full,
  output decode_t [1:0] issue_instr,
  input  logic    [1:0] issue_cnt,
  output logic          queue_empty
);

  localparam int CNT_W = PTR_W + 1;

  decode_t          mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [1:0]       push_n, pop_n, issue_lim;

  assign head_p1 = head_q + PTR_W'(1);
  assign tail_p1 = tail_q + PTR_W'(1);

  // Full is judged on the pre-edge count so issue_cnt never reaches push.
  assign queue_full  = count_q > CNT_W'(DEPTH - 2);
  assign queue_empty = count_q == '0;

  always_comb begin
    push_n = '0;
    if (!queue_full && in_cnt != 2'd3) begin
      push_n = in_cnt;
    end
  end

  always_comb begin
    issue_lim = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;
    pop_n     = issue_lim;
    if (CNT_W'(issue_lim) > count_q) begin
      pop_n = count_q[1:0];
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (push_n != 2'd0) begin
        mem_q[tail_q] <= in_instr[0];
      end
      if (push_n == 2'd2) begin
        mem_q[tail_p1] <= in_instr[1];
      end
    end
  end

  // A zero slot is the invalid marker issue relies on.
  always_comb begin
    issue_instr[0] = '0;
    issue_instr[1] = '0;
    if (count_q >= CNT_W'(1)) begin
      issue_instr[0] = mem_q[head_q];
    end
    if (count_q >= CNT_W'(2)) begin
      issue_instr[1] = mem_q[head_p1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= CNT_W'(DEPTH))
        else $error("instr_queue: count overflow");
      assert (tail_q == head_q + count_q[PTR_W-1:0])
        else $error("instr_queue: pointer/count skew");
      assert (CNT_W'(push_n) <= CNT_W'(DEPTH) - count_q)
        else $error("instr_queue: write to occupied slot");
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed plus random stimulus for instr_queue,
// checked against a queue-based reference model.
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          flush;
  decode_t [1:0] in_instr;
  logic    [1:0] in_cnt;
  logic          queue_full;
  decode_t [1:0] issue_instr;
  logic    [1:0] issue_cnt;
  logic          queue_empty;

  int vectors = 0;
  int miscompares = 0;

  decode_t mq[$];

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_instr   (in_instr),
    .in_cnt     (in_cnt),
    .queue_full (queue_full),
    .issue_instr(issue_instr),
    .issue_cnt  (issue_cnt),
    .queue_empty(queue_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic decode_t mk(input logic [31:0] pc);
    decode_t d;
    d.pc  = pc;
    d.ir  = $urandom;
    d.rd  = 5'($urandom);
    d.rs1 = 5'($urandom);
    d.rs2 = 5'($urandom);
    d.fu  = 4'($urandom);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    decode_t e0, e1;
    e0 = (mq.size() >= 1) ? mq[0] : decode_t'('0);
    e1 = (mq.size() >= 2) ? mq[1] : decode_t'('0);
    chk({tag, ".empty"}, 128'(queue_empty), 128'(mq.size() == 0));
    chk({tag, ".full"}, 128'(queue_full), 128'(mq.size() > DEPTH - 2));
    chk({tag, ".slot0"}, 128'(issue_instr[0]), 128'(e0));
    chk({tag, ".slot1"}, 128'(issue_instr[1]), 128'(e1));
  endtask

  // Drive one cycle, advance the model by the queue rules, then compare.
  task automatic step(input string tag, input bit fl, input logic [1:0] ic,
                      input decode_t a, input decode_t b,
                      input logic [1:0] icnt);
    int n, pn, ie, pp;
    flush       = fl;
    in_cnt      = ic;
    in_instr[0] = a;
    in_instr[1] = b;
    issue_cnt   = icnt;
    n  = mq.size();
    pn = (n <= DEPTH - 2 && ic != 2'd3) ? int'(ic) : 0;
    ie = (icnt == 2'd3) ? 2 : int'(icnt);
    pp = (ie < n) ? ie : n;
    if (fl) begin
      mq.delete();
    end else begin
      repeat (pp) void'(mq.pop_front());
      if (pn >= 1) mq.push_back(a);
      if (pn == 2) mq.push_back(b);
    end
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_cnt    = 2'd0;
    issue_cnt = 2'd0;
    compare_all(tag);
  endtask

  initial begin
    decode_t z, prev1;
    logic [31:0] p;
    z = '0;
    reset = 1'b1;
    flush = 1'b0;
    in_cnt = 2'd0;
    issue_cnt = 2'd0;
    in_instr = '0;
    #1;
    compare_all("reset");
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    compare_all("release");

    step("push1", 0, 2'd1, mk(32'hBFC0_0000), z, 2'd0);
    chk("push1.pc", 128'(issue_instr[0].pc), 128'(32'hBFC0_0000));
    chk("push1.s1", 128'(issue_instr[1]), 128'(0));
    chk("push1.ne", 128'(queue_empty), 128'(0));

    // Fill from count 1 by two per cycle up to 15.
    step("fl0", 1, 2'd0, z, z, 2'd0);
    p = 32'h1000_0000;
    step("fill1", 0, 2'd1, mk(p), z, 2'd0);
    for (int i = 0; i < 7; i++) begin
      step("fill", 0, 2'd2, mk(p + 32'(4 + 8 * i)), mk(p + 32'(8 + 8 * i)),
           2'd0);
    end
    chk("full.rise", 128'(queue_full), 128'(1));
    step("full.drop", 0, 2'd2, mk(32'hDEAD_0000), mk(32'hDEAD_0004), 2'd0);
    chk("full.cnt", 128'(dut.count_q), 128'(15));
    chk("full.h0", 128'(issue_instr[0].pc), 128'(p));
    chk("full.h1", 128'(issue_instr[1].pc), 128'(p + 32'd4));
    step("full.pop2", 0, 2'd2, mk(32'hDEAD_0008), mk(32'hDEAD_000C), 2'd2);
    chk("full.cons", 128'(dut.count_q), 128'(13));
    chk("full.cons.h", 128'(issue_instr[0].pc), 128'(p + 32'd8));

    // Steady state at count 4 across many wraps.
    step("fl1", 1, 2'd0, z, z, 2'd0);
    p = 32'h2000_0000;
    step("ss0", 0, 2'd2, mk(p), mk(p + 32'd4), 2'd0);
    step("ss1", 0, 2'd2, mk(p + 32'd8), mk(p + 32'd12), 2'd0);
    for (int k = 0; k < 20; k++) begin
      step("ss", 0, 2'd2, mk(p + 32'(16 + 8 * k)), mk(p + 32'(20 + 8 * k)),
           2'd2);
      chk("ss.head", 128'(issue_instr[0].pc), 128'(p + 32'(8 * (k + 1))));
      chk("ss.cnt", 128'(dut.count_q), 128'(4));
    end

    // Over-pop and single pop.
    step("fl2", 1, 2'd0, z, z, 2'd0);
    step("op.push", 0, 2'd1, mk(32'h3000_0000), z, 2'd0);
    step("op.pop", 0, 2'd0, z, z, 2'd2);
    chk("op.empty", 128'(queue_empty), 128'(1));
    step("sp.a", 0, 2'd2, mk(32'h3000_0010), mk(32'h3000_0014), 2'd0);
    step("sp.b", 0, 2'd1, mk(32'h3000_0018), z, 2'd0);
    prev1 = mq[1];
    step("sp.pop1", 0, 2'd0, z, z, 2'd1);
    chk("sp.shift", 128'(issue_instr[0]), 128'(prev1));
    chk("sp.cnt", 128'(dut.count_q), 128'(2));
    step("ill", 0, 2'd3, mk(32'h3000_0020), mk(32'h3000_0024), 2'd3);
    chk("ill.empty", 128'(queue_empty), 128'(1));

    // Flush beats simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      step("fp", 0, 2'd2, mk(32'h4000_0000 + 32'(8 * i)),
           mk(32'h4000_0004 + 32'(8 * i)), 2'd0);
    end
    step("fp.flush", 1, 2'd2, mk(32'h4000_1000), mk(32'h4000_1004), 2'd2);
    chk("fp.empty", 128'(queue_empty), 128'(1));
    chk("fp.slots", 128'(issue_instr), 128'(0));
    step("fp.push", 0, 2'd1, mk(32'h8000_0100), z, 2'd0);
    chk("fp.pc", 128'(issue_instr[0].pc), 128'(32'h8000_0100));

    // Asynchronous reset between edges at count 5.
    step("ar.a", 0, 2'd2, mk(32'h5000_0000), mk(32'h5000_0004), 2'd0);
    step("ar.b", 0, 2'd2, mk(32'h5000_0008), mk(32'h5000_000C), 2'd0);
    chk("ar.cnt", 128'(dut.count_q), 128'(5));
    #2 reset = 1'b1;
    #1;
    mq.delete();
    compare_all("ar.mid");
    #1 reset = 1'b0;
    step("ar.push", 0, 2'd1, mk(32'h0000_1234), z, 2'd0);
    chk("ar.idx0", 128'(dut.mem_q[0].pc), 128'(32'h0000_1234));

    // Random traffic, including illegal counts and occasional flush.
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom % 32) == 0, 2'($urandom), mk($urandom),
           mk($urandom), 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Dual-ported decoded-instruction FIFO between the decode stage and the dual-issue stage.
- Each cycle it accepts 0–2 decoded instructions from decode and presents the two oldest entries to issue.
- Each cycle it retires 0–2 entries according to the issue stage's issue_cnt.
- Provides the queue_empty and queue_full status the issue and fetch/decode stages consume.

Parameters:
- DEPTH, 16, number of decode_t entries; power of two, >= 4.
- PTR_W, $clog2(DEPTH), head/tail pointer width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  discard all entries (branch mispredict / exception redirect).
- in_instr  input  2 x $bits(decode_t)  decoded instructions; [0] is older than [1].
- in_cnt  input  2  number of valid in_instr slots: 0, 1 or 2.
- queue_full  output  1  fewer than 2 free entries; the producer must not push.
- issue_instr  output  2 x $bits(decode_t)  two oldest entries; [0] is the head.
- issue_cnt  input  2  number of head entries the issue stage consumed this cycle (0–2).
- queue_empty  output  1  no valid entries.

Behaviour:
- Storage:
  - Circular buffer mem[DEPTH] of decode_t.
  - head and tail pointers, PTR_W bits each, wrap modulo DEPTH.
  - count register, PTR_W+1 bits, range 0..DEPTH.
- Reset (asynchronous, active-high): head=0, tail=0, count=0. mem contents are don't-care.
  - Outputs during reset: issue_instr='0, queue_empty=1, queue_full=0.
- Outputs are purely combinational from registered state only; there is no input-to-output path:
  - issue_instr[0] = mem[head] if count>=1, else '0.
  - issue_instr[1] = mem[head+1 mod DEPTH] if count>=2, else '0.
  - The all-zero slot (PC=='0) is the invalid-slot encoding issue relies on. It must appear whenever an entry is absent, including a lone branch whose delay slot has not yet arrived.
  - queue_empty = (count==0).
  - queue_full = (count > DEPTH-2).
- Push:
  - push_n = in_cnt if (~queue_full && in_cnt<=2), else 0.
  - in_cnt==3 is illegal and treated as 0.
  - A push while full is dropped silently; the producer must hold its data.
  - push_n>=1: mem[tail] <= in_instr[0]. push_n==2: also mem[tail+1] <= in_instr[1].
  - tail <= tail + push_n (mod DEPTH).
- Pop:
  - pop_n = min(issue_cnt, count), evaluated against the pre-edge count.
  - issue_cnt==3 is treated as 2.
  - head <= head + pop_n.
  - Entries pushed this cycle are never popped this cycle (no bypass).
- Count update: count <= count + push_n - pop_n. Simultaneous push and pop in the same cycle is legal.
- Full is decided on the pre-edge count:
  - At count==DEPTH-1, a push is refused even if issue pops 2 the same cycle (conservative; avoids a combinational loop through issue_cnt).
- Flush, synchronous:
  - Takes priority over push and pop in the same cycle.
  - Next state: head=0, tail=0, count=0. in_instr presented in the flush cycle is discarded.
  - Next cycle: queue_empty=1, issue_instr='0.
- Reset asserted mid-operation clears state immediately, independent of clk.
- Wrap-around: pointer arithmetic is mod DEPTH. A 2-entry push or pop straddling index DEPTH-1 → 0 must order entries correctly.
- Invariants (assert in simulation):
  - count<=DEPTH.
  - tail == head + count (mod DEPTH).
  - No write to an occupied slot.

Test Plan:
- Reset release → queue_empty=1, queue_full=0, issue_instr[0]=issue_instr[1]='0. Push 1 entry (PC=0xBFC00000) → next cycle issue_instr[0].PC=0xBFC00000, issue_instr[1]='0, queue_empty=0.
- Push 2/cycle (PCs 0x..00, 0x..04, …) with issue_cnt=0 until full → queue_full rises at count=15 (DEPTH=16). A further push of 2 is dropped: count stays 15 and the head still shows PC 0x..00/0x..04.
- Steady state with count=4: push 2 and issue_cnt=2 each cycle for 20 cycles (forces wrap) → count constant at 4. The head PC sequence advances by 8 per cycle with no gap or duplicate.
- count=1, issue_cnt=2 → exactly 1 entry popped, count=0, queue_empty=1. count=3 with issue_cnt=1 and in_cnt=0 → issue_instr[0] becomes the former [1], count=2.
- count=6, flush=1 together with in_cnt=2 and issue_cnt=2 → next cycle count=0, queue_empty=1, issue_instr='0. The following push of PC 0x80000100 appears at issue_instr[0].
- Assert reset asynchronously between clock edges with count=5 → outputs go empty immediately. After release, the first push lands at index 0.
